// File: rtl/mdu_sched_pkg.sv
// Shared MDU operation codes, FSM state encoding and op-class helpers.
package mdu_sched_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic is_md(input logic [3:0] t);
    return (t == MDU_MULT) || (t == MDU_MULTU) || (t == MDU_DIV) || (t == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sched_arith.sv
// mdu_arith: combinational product / quotient / remainder for the MDU.
// Signedness follows MDU_type; one multiplier and one divider are shared.
module mdu_arith
  import mdu_sched_pkg::*;
(
  input  logic [3:0]  MDU_type,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div0
);

  logic        sgn;
  logic [63:0] ea, eb;
  logic [31:0] ua, ub, uq, ur;

  // Sign-extend for signed ops, zero-extend otherwise; the low 64 bits of
  // the 64x64 product are then correct for both flavours. Signed divide is
  // done on magnitudes, which also yields 0x80000000 / -1 = 0x80000000 r 0.
  always_comb begin
    sgn  = (MDU_type == MDU_MULT) || (MDU_type == MDU_DIV);
    ea   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb   = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod = ea * eb;

    div0 = (b == 32'd0);
    ua   = (sgn && a[31]) ? (32'd0 - a) : a;
    ub   = (sgn && b[31]) ? (32'd0 - b) : b;
    if (div0) ub = 32'd1;  // keep the divider X-free; result is discarded
    uq   = ua / ub;
    ur   = ua % ub;
    quot = (sgn && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
    rem  = (sgn && a[31]) ? (32'd0 - ur) : ur;
  end

endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle mult/div scheduler owning HI/LO.
// Fixed latencies are modelled with a down-counter; results are computed at
// issue and held in pending registers until the last busy cycle ends.
// Option: MDU_DIV0_FAST_EN makes divide-by-zero finish after one busy cycle.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDU_type,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        D_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      phi_q, phi_d, plo_q, plo_d;
  logic             pwr_q, pwr_d;  // pending result is to be committed

  logic [63:0] prod;
  logic [31:0] quot, rem;
  logic        div0, go;

  mdu_arith u_arith (
    .MDU_type (MDU_type),
    .a        (a),
    .b        (b),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div0     (div0)
  );

  assign busy = (state_q != ST_IDLE);
  assign go   = start & ~flush & ~busy;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Only an unflushed mult/div in E conflicts with a D-stage MDU op; an
  // in-flight operation always does.
  assign stall_req = ~reset & D_md_use &
                     (busy | (start & ~flush & is_md(MDU_type)));

  // Zero-latency HI/LO read for mfhi/mflo.
  always_comb begin
    case (MDU_type)
      MDU_MFHI: mf_data = hi_q;
      MDU_MFLO: mf_data = lo_q;
      default:  mf_data = 32'd0;
    endcase
  end

  // State, counter, HI/LO and pending result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

  // Next-state: issue from IDLE, count down while busy, commit on cnt == 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          case (MDU_type)
            MDU_MULT, MDU_MULTU: begin
              phi_d   = prod[63:32];
              plo_d   = prod[31:0];
              pwr_d   = 1'b1;
              cnt_d   = CNT_W'(MULT_LAT);
              state_d = ST_MULT;
            end
            MDU_DIV, MDU_DIVU: begin
              phi_d   = rem;
              plo_d   = quot;
              pwr_d   = ~div0;  // divide by zero leaves HI/LO untouched
`ifdef MDU_DIV0_FAST_EN
              cnt_d   = div0 ? CNT_W'(1) : CNT_W'(DIV_LAT);
`else
              cnt_d   = CNT_W'(DIV_LAT);
`endif
              state_d = ST_DIV;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MULT, ST_DIV: begin
        if (cnt_q == CNT_W'(1)) begin
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Scoreboard bench for mdu_sched: stimulus pushes expected completions and
// mf reads into queues; a negedge monitor pops and compares.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

`ifdef MDU_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 10;
`endif

  logic        clk = 1'b0;
  logic        reset, start, flush, D_md_use;
  logic [3:0]  MDU_type;
  logic [31:0] a, b;
  logic        busy, stall_req;
  logic [31:0] mf_data, hi, lo;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } cexp_t;

  cexp_t       cq[$];
  logic [31:0] mq[$];

  mdu_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .MDU_type  (MDU_type),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .D_md_use  (D_md_use),
    .busy      (busy),
    .stall_req (stall_req),
    .mf_data   (mf_data),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_c(input logic [31:0] h, input logic [31:0] l, input int lat);
    cexp_t e;
    e.hi = h; e.lo = l; e.lat = lat;
    cq.push_back(e);
  endtask

  // Monitor: completion on busy falling, mf reads whenever one is in E.
  logic prev_busy = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    cexp_t e;
    if (busy === 1'b1) begin
      bcnt++;
    end else if (prev_busy === 1'b1) begin
      if (cq.size() == 0) begin
        chk("unexpected_completion", 64'd1, 64'd0);
      end else begin
        e = cq.pop_front();
        chk("cmp_hi", hi, e.hi);
        chk("cmp_lo", lo, e.lo);
        chk("cmp_busy_cycles", bcnt, e.lat);
      end
      bcnt = 0;
    end
    prev_busy = busy;
    if (reset === 1'b0 && start === 1'b1 && busy === 1'b0 &&
        (MDU_type == MDU_MFHI || MDU_type == MDU_MFLO)) begin
      if (mq.size() == 0) chk("unexpected_mf", 64'd1, 64'd0);
      else                chk("mf_data", mf_data, mq.pop_front());
    end
    if (start === 1'b1 && busy === 1'b1 && flush === 1'b0)
      chk("start_while_busy", 64'd1, 64'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] t, input logic [31:0] va,
                       input logic [31:0] vb, input logic fl);
    start = 1'b1; MDU_type = t; a = va; b = vb; flush = fl;
    tick();
    start = 1'b0; MDU_type = MDU_NONE; flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b1; MDU_type = MDU_MULT; a = 32'd3; b = 32'd3;
    flush = 1'b0; D_md_use = 1'b1;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", stall_req, 1'b0);
    start = 1'b0; MDU_type = MDU_NONE; D_md_use = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // mult -1 * 2 with a D-stage MDU op waiting: stall through every busy cycle
    D_md_use = 1'b1;
    exp_c(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    start = 1'b1; MDU_type = MDU_MULT; a = 32'hFFFF_FFFF; b = 32'd2;
    #1 chk("stall_issue", stall_req, 1'b1);
    tick();
    start = 1'b0; MDU_type = MDU_NONE;
    n = 0;
    while (busy && n < 40) begin
      #1 chk("stall_busy", stall_req, 1'b1);
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
    start = 1'b1; MDU_type = MDU_MFLO;
    mq.push_back(32'hFFFF_FFFE);
    #1 chk("stall_after", stall_req, 1'b0);
    tick();
    start = 1'b0; MDU_type = MDU_NONE; D_md_use = 1'b0;

    // multu same operands
    exp_c(32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle();
    mq.push_back(32'h0000_0001);
    issue(MDU_MFHI, 32'd0, 32'd0, 1'b0);

    // div -7 / 2 -> q -3, r -1
    exp_c(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();

    // divu 7 / 2, then mult issued on the first idle cycle
    exp_c(32'd1, 32'd3, 10);
    issue(MDU_DIVU, 32'd7, 32'd2, 1'b0);
    wait_idle();
    exp_c(32'd0, 32'd12, 5);
    issue(MDU_MULT, 32'd3, 32'd4, 1'b0);
    wait_idle();

    // signed overflow
    exp_c(32'd0, 32'h8000_0000, 10);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    mq.push_back(32'h8000_0000);
    issue(MDU_MFLO, 32'd0, 32'd0, 1'b0);

    // mthi then mfhi; flushed mthi leaves HI alone
    issue(MDU_MTHI, 32'h1234, 32'd0, 1'b0);
    mq.push_back(32'h1234);
    issue(MDU_MFHI, 32'd0, 32'd0, 1'b0);
    issue(MDU_MTHI, 32'h5678, 32'd0, 1'b1);
    mq.push_back(32'h1234);
    issue(MDU_MFHI, 32'd0, 32'd0, 1'b0);

    // flushed mult never starts
    issue(MDU_MULT, 32'd3, 32'd3, 1'b1);
    #1 chk("flush_no_busy", busy, 1'b0);
    tick();
    mq.push_back(32'h8000_0000);
    issue(MDU_MFLO, 32'd0, 32'd0, 1'b0);

    // mf_data is zero for non-mf op codes
    MDU_type = MDU_MULT;
    #1 chk("mf_zero", mf_data, 32'd0);
    MDU_type = MDU_NONE;
    tick();

    // divide by zero leaves preloaded HI/LO
    issue(MDU_MTHI, 32'hA, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'hB, 32'd0, 1'b0);
    exp_c(32'hA, 32'hB, DIV0_LAT);
    issue(MDU_DIV, 32'd5, 32'd0, 1'b0);
    wait_idle();
    mq.push_back(32'hA);
    issue(MDU_MFHI, 32'd0, 32'd0, 1'b0);

    // reset in busy cycle 3 of a divu: result is dropped
    exp_c(32'd0, 32'd0, 3);
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    tick(); tick();
    reset = 1'b1; D_md_use = 1'b1;
    #1 chk("rst_stall_gate", stall_req, 1'b0);
    tick();
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    reset = 1'b0; D_md_use = 1'b0;
    repeat (12) tick();
    chk("rst_no_commit_hi", hi, 32'd0);
    chk("rst_no_commit_lo", lo, 32'd0);

    repeat (2) tick();
    chk("cq_drained", cq.size(), 0);
    chk("mq_drained", mq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
